// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, select encodings, request payload
// and the arbiter state encoding.
package alu_pkg;

  localparam int DEF_SEL_SIZE   = 4;
  localparam int DEF_SHIFT_SIZE = 5;
  localparam int DEF_XLEN       = 32;

  // Select encodings understood by arithmeticLogicUnit
  typedef enum logic [DEF_SEL_SIZE-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [DEF_SEL_SIZE-1:0]   sel;
    logic [DEF_SHIFT_SIZE-1:0] shift_amt;
    logic [DEF_XLEN-1:0]       data_a;
    logic [DEF_XLEN-1:0]       data_b;
  } alu_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at N-1. Grant is one-hot, or zero when nothing is requesting.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
      idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one execute-stage ALU between NUM_REQ requesters. Operations are
// granted round-robin, executed for one cycle from registered operands, and
// returned with the owner's ID over a valid/ready response port.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int SEL_SIZE   = DEF_SEL_SIZE,
  parameter int SHIFT_SIZE = DEF_SHIFT_SIZE,
  parameter int XLEN       = DEF_XLEN,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*SEL_SIZE-1:0]   req_sel,
  input  logic [NUM_REQ*SHIFT_SIZE-1:0] req_shift_amt,
  input  logic [NUM_REQ*XLEN-1:0]       req_data_a,
  input  logic [NUM_REQ*XLEN-1:0]       req_data_b,
  output logic                          alu_enable,
  output logic [SEL_SIZE-1:0]           alu_sel,
  output logic [SHIFT_SIZE-1:0]         alu_shift_amt,
  output logic [XLEN-1:0]               alu_data_in_a,
  output logic [XLEN-1:0]               alu_data_in_b,
  input  logic [XLEN-1:0]               alu_data_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [XLEN-1:0]               rsp_data,
  output logic [1:0]                    state_dbg
);

  // Handshakes: a transfer happens on an edge where valid & ready are both 1.
  // Request side: req_ready is one-hot to the round-robin winner, asserted in
  // IDLE or in RESP when the response retires on the same edge.
  // Response side: rsp_valid/rsp_id/rsp_data hold until rsp_ready is seen.

  arb_state_e state, state_next;

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       ptr_next;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  can_accept;
  logic                  fire;

  logic [SEL_SIZE-1:0]   sel_q;
  logic [SHIFT_SIZE-1:0] shift_q;
  logic [XLEN-1:0]       data_a_q;
  logic [XLEN-1:0]       data_b_q;
  logic [ID_W-1:0]       id_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign req_ready  = (rst_n && can_accept) ? grant : '0;
  assign fire       = |(req_valid & req_ready);
  assign ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = fire ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: the ALU only ever sees registered operands
  always_comb begin
    alu_enable    = (state == EXEC);
    alu_sel       = sel_q;
    alu_shift_amt = shift_q;
    alu_data_in_a = data_a_q;
    alu_data_in_b = data_b_q;
    state_dbg     = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      sel_q     <= '0;
      shift_q   <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (fire) begin
        sel_q    <= req_sel[int'(grant_idx)*SEL_SIZE +: SEL_SIZE];
        shift_q  <= req_shift_amt[int'(grant_idx)*SHIFT_SIZE +: SHIFT_SIZE];
        data_a_q <= req_data_a[int'(grant_idx)*XLEN +: XLEN];
        data_b_q <= req_data_b[int'(grant_idx)*XLEN +: XLEN];
        id_q     <= grant_idx;
        rr_ptr   <= ptr_next;
      end
      // Retire-and-grant in RESP also drops rsp_valid; EXEC re-raises it
      if (state == EXEC) begin
        rsp_data  <= alu_data_out;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU drives alu_data_out, and each test
// task checks the arbiter against expectations derived from the request stream.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int SEL     = 4;
  localparam int SH      = 5;
  localparam int XLEN    = 32;
  localparam int ID_W    = 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*SEL-1:0]  req_sel;
  logic [NUM_REQ*SH-1:0]   req_shift_amt;
  logic [NUM_REQ*XLEN-1:0] req_data_a;
  logic [NUM_REQ*XLEN-1:0] req_data_b;
  logic                    alu_enable;
  logic [SEL-1:0]          alu_sel;
  logic [SH-1:0]           alu_shift_amt;
  logic [XLEN-1:0]         alu_data_in_a;
  logic [XLEN-1:0]         alu_data_in_b;
  logic [XLEN-1:0]         alu_data_out;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [XLEN-1:0]         rsp_data;
  logic [1:0]              state_dbg;

  alu_req_t ops [NUM_REQ];
  logic [ID_W+XLEN-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  alu_arbiter #(
    .NUM_REQ(NUM_REQ), .SEL_SIZE(SEL), .SHIFT_SIZE(SH), .XLEN(XLEN), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_shift_amt(req_shift_amt), .req_data_a(req_data_a),
    .req_data_b(req_data_b), .alu_enable(alu_enable), .alu_sel(alu_sel),
    .alu_shift_amt(alu_shift_amt), .alu_data_in_a(alu_data_in_a),
    .alu_data_in_b(alu_data_in_b), .alu_data_out(alu_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always_comb begin
    req_sel       = '0;
    req_shift_amt = '0;
    req_data_a    = '0;
    req_data_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_sel[i*SEL +: SEL]        = ops[i].sel;
      req_shift_amt[i*SH +: SH]    = ops[i].shift_amt;
      req_data_a[i*XLEN +: XLEN]   = ops[i].data_a;
      req_data_b[i*XLEN +: XLEN]   = ops[i].data_b;
    end
  end

  function automatic logic [XLEN-1:0] alu_ref(logic [SEL-1:0] s, logic [SH-1:0] sh,
                                               logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    case (s)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $signed(a) >>> sh;
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] op_result(alu_req_t r);
    return alu_ref(r.sel, r.shift_amt, r.data_a, r.data_b);
  endfunction

  // Stand-in for arithmeticLogicUnit; a poison value when not enabled
  always_comb
    alu_data_out = alu_enable ? alu_ref(alu_sel, alu_shift_amt, alu_data_in_a, alu_data_in_b)
                              : 32'hDEAD_BEEF;

  function automatic alu_req_t rand_op();
    alu_req_t r;
    r.sel       = 4'($urandom_range(0, 9));
    r.shift_amt = 5'($urandom);
    r.data_a    = $urandom;
    r.data_b    = $urandom;
    return r;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ops[0]    = rand_op();
    ops[1]    = rand_op();
    #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready_async: got %b exp 00", req_ready); else n_pass++;
    tick();
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b exp 00", req_ready); else n_pass++;
    n_checks++; if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d exp %0d", state_dbg, IDLE); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d exp 0", rsp_id); else n_pass++;
    n_checks++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h exp 0", rsp_data); else n_pass++;
    n_checks++; if (alu_enable !== 1'b0) $display("FAIL reset_alu_enable: got %b exp 0", alu_enable); else n_pass++;
    n_checks++; if ({alu_sel, alu_shift_amt, alu_data_in_a, alu_data_in_b} !== '0)
      $display("FAIL reset_alu_inputs: got %h/%h/%h/%h exp all 0", alu_sel, alu_shift_amt, alu_data_in_a, alu_data_in_b);
    else n_pass++;
    req_valid = '0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    ops[0]    = '{sel: ALU_ADD, shift_amt: 5'd0, data_a: 32'd5, data_b: 32'd7};
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (alu_enable !== 1'b1) $display("FAIL single_enable: got %b exp 1", alu_enable); else n_pass++;
    n_checks++; if ({alu_sel, alu_data_in_a, alu_data_in_b} !== {4'(ALU_ADD), 32'd5, 32'd7})
      $display("FAIL single_alu_in: got %h/%h/%h exp 0/5/7", alu_sel, alu_data_in_a, alu_data_in_b);
    else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_early_rsp: got %b exp 0", rsp_valid); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd12})
      $display("FAIL single_rsp: got v=%b id=%0d d=%h exp v=1 id=0 d=0000000c", rsp_valid, rsp_id, rsp_data);
    else n_pass++;
    n_checks++; if (alu_enable !== 1'b0) $display("FAIL single_enable_resp: got %b exp 0", alu_enable); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || state_dbg !== IDLE)
      $display("FAIL single_retire: got v=%b st=%0d exp v=0 st=0", rsp_valid, state_dbg);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    ops[0]    = '{sel: ALU_SUB, shift_amt: 5'd0, data_a: 32'd10, data_b: 32'd3};
    ops[1]    = '{sel: ALU_XOR, shift_amt: 5'd0, data_a: 32'hF0, data_b: 32'h0F};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL simul_first_grant: got %b exp 01", req_ready); else n_pass++;
    tick();
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL simul_exec_ready: got %b exp 00", req_ready); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd7})
      $display("FAIL simul_rsp0: got v=%b id=%0d d=%h exp v=1 id=0 d=00000007", rsp_valid, rsp_id, rsp_data);
    else n_pass++;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL simul_second_grant: got %b exp 10", req_ready); else n_pass++;
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'hFF})
      $display("FAIL simul_rsp1: got v=%b id=%0d d=%h exp v=1 id=1 d=000000ff", rsp_valid, rsp_id, rsp_data);
    else n_pass++;
    tick();
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL simul_ptr_wrap: got %b exp 01", req_ready); else n_pass++;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_fairness();
    int n_rsp;
    int winner;
    logic [ID_W+XLEN-1:0] got;
    logic [NUM_REQ-1:0] exp_ready;
    do_reset();
    exp_q.delete();
    n_rsp     = 0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      req_valid = (cyc < 16) ? 2'b11 : 2'b00;
      ops[0]    = rand_op();
      ops[1]    = rand_op();
      #1;
      winner    = (cyc / 2) % 2;
      exp_ready = (cyc < 16 && cyc % 2 == 0) ? NUM_REQ'(1 << winner) : '0;
      n_checks++; if (req_ready !== exp_ready)
        $display("FAIL fair_ready c%0d: got %b exp %b", cyc, req_ready, exp_ready);
      else n_pass++;
      n_checks++; if (rsp_valid !== (cyc >= 2 && cyc % 2 == 0))
        $display("FAIL fair_rsp_timing c%0d: got %b", cyc, rsp_valid);
      else n_pass++;
      if (rsp_valid && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_rsp++;
        n_checks++; if ({rsp_id, rsp_data} !== got)
          $display("FAIL fair_rsp c%0d: got id=%0d d=%h exp id=%0d d=%h", cyc, rsp_id, rsp_data, got[XLEN], got[XLEN-1:0]);
        else n_pass++;
      end
      if (exp_ready != '0) exp_q.push_back({ID_W'(winner), op_result(ops[winner])});
      tick();
    end
    n_checks++; if (n_rsp != 8 || exp_q.size() != 0)
      $display("FAIL fair_count: got %0d responses, %0d left, exp 8 and 0", n_rsp, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    alu_req_t held;
    logic [XLEN-1:0] exp_d;
    do_reset();
    ops[1]    = rand_op();
    held      = ops[1];
    exp_d     = op_result(held);
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b11;
    tick();
    for (int c = 0; c < 5; c++) begin
      ops[0] = rand_op();
      ops[1] = rand_op();
      #1;
      n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, exp_d})
        $display("FAIL bp_hold c%0d: got v=%b id=%0d d=%h exp v=1 id=1 d=%h", c, rsp_valid, rsp_id, rsp_data, exp_d);
      else n_pass++;
      n_checks++; if (req_ready !== 2'b00 || alu_enable !== 1'b0)
        $display("FAIL bp_stall c%0d: got ready=%b en=%b exp 00/0", c, req_ready, alu_enable);
      else n_pass++;
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if ({rsp_valid, rsp_data} !== {1'b1, exp_d})
      $display("FAIL bp_release: got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_data, exp_d);
    else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || state_dbg !== IDLE)
      $display("FAIL bp_done: got v=%b st=%0d exp v=0 st=0", rsp_valid, state_dbg);
    else n_pass++;
  endtask

  task automatic test_shift();
    do_reset();
    ops[1]    = '{sel: ALU_SLL, shift_amt: 5'd31, data_a: 32'd1, data_b: $urandom};
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'h8000_0000})
      $display("FAIL shift_sll31: got v=%b id=%0d d=%h exp v=1 id=1 d=80000000", rsp_valid, rsp_id, rsp_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ops[0]    = rand_op();
    ops[0].data_a = ops[0].data_a | 32'h1;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    #1;
    n_checks++; if (alu_enable !== 1'b1) $display("FAIL midrst_exec: got %b exp 1", alu_enable); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++; if (state_dbg !== IDLE || rsp_valid !== 1'b0 || alu_enable !== 1'b0)
      $display("FAIL midrst_state: got st=%0d v=%b en=%b exp 0/0/0", state_dbg, rsp_valid, alu_enable);
    else n_pass++;
    n_checks++; if ({rsp_id, rsp_data, alu_data_in_a, alu_data_in_b, alu_sel} !== '0)
      $display("FAIL midrst_clear: got id=%0d d=%h a=%h b=%h s=%h exp all 0", rsp_id, rsp_data, alu_data_in_a, alu_data_in_b, alu_sel);
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL midrst_ghost c%0d: got v=%b exp 0", c, rsp_valid); else n_pass++;
    end
  endtask

  // Randomized traffic against a transaction-level model
  task automatic test_random();
    int m_ptr;
    bit m_exec, m_resp, can;
    int win, idx;
    logic [NUM_REQ-1:0] exp_ready;
    logic [ID_W+XLEN-1:0] front;
    do_reset();
    exp_q.delete();
    m_ptr = 0; m_exec = 0; m_resp = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (cyc < 312) begin
        req_valid = NUM_REQ'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      ops[0] = rand_op();
      ops[1] = rand_op();
      #1;
      win = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
      can       = !m_exec && (!m_resp || rsp_ready);
      exp_ready = (can && win >= 0) ? NUM_REQ'(1 << win) : '0;
      n_checks++; if (req_ready !== exp_ready)
        $display("FAIL rand_ready c%0d: got %b exp %b", cyc, req_ready, exp_ready);
      else n_pass++;
      n_checks++; if (alu_enable !== m_exec || rsp_valid !== m_resp)
        $display("FAIL rand_phase c%0d: got en=%b v=%b exp en=%b v=%b", cyc, alu_enable, rsp_valid, m_exec, m_resp);
      else n_pass++;
      if (m_resp) begin
        front = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_checks++; if ({rsp_id, rsp_data} !== front)
          $display("FAIL rand_rsp c%0d: got id=%0d d=%h exp id=%0d d=%h", cyc, rsp_id, rsp_data, front[XLEN], front[XLEN-1:0]);
        else n_pass++;
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_resp = 0;
        end
      end
      if (m_exec) begin
        m_exec = 0;
        m_resp = 1;
      end
      if (exp_ready != '0) begin
        exp_q.push_back({ID_W'(win), op_result(ops[win])});
        m_ptr  = (win + 1) % NUM_REQ;
        m_exec = 1;
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d left exp 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    ops[0]    = '0;
    ops[1]    = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_shift();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU (arithmeticLogicUnit inside executeCycle) between NUM_REQ requesters, e.g. the integer pipeline and the branch/address unit.
- Accepts operations over per-requester valid/ready handshakes and grants by round-robin.
- Drives the ALU operand, select and enable inputs from registered state, then returns the ALU result with the requester ID over a valid/ready response port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- SEL_SIZE, 4, ALU select width
- SHIFT_SIZE, 5, ALU shift-amount width
- XLEN, 32, datapath width
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_sel  in  NUM_REQ*SEL_SIZE  packed ALU selects; requester i at slice i
- req_shift_amt  in  NUM_REQ*SHIFT_SIZE  packed shift amounts
- req_data_a  in  NUM_REQ*XLEN  packed operand A
- req_data_b  in  NUM_REQ*XLEN  packed operand B
- alu_enable  out  1  ALU enable
- alu_sel  out  SEL_SIZE  to ALU
- alu_shift_amt  out  SHIFT_SIZE  to ALU
- alu_data_in_a  out  XLEN  to ALU
- alu_data_in_b  out  XLEN  to ALU
- alu_data_out  in  XLEN  combinational ALU result
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_data  out  XLEN  registered ALU result

Behaviour:
- Clock and reset: clk and rst_n; reset is synchronous and active-low.
- FSM states: IDLE, EXEC, RESP.
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, rr_ptr=0
  - operand, select and shift registers = 0
  - rsp_valid=0, rsp_id=0, rsp_data=0, alu_enable=0
  - req_ready is 0 while rst_n=0.
- Reset mid-operation drops any in-flight operation and any pending response without handshake.
- Arbitration is combinational from req_valid and rr_ptr:
  - The winner is the first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 only in IDLE, or in RESP when rsp_ready=1; all other bits are 0.
- A handshake is req_valid[i] & req_ready[i]. On the handshake edge:
  - latch sel, shift_amt, data_a, data_b and id=i
  - rr_ptr <= (i+1) mod NUM_REQ
  - state <= EXEC
- rr_ptr changes only on a grant.
- EXEC (exactly one cycle):
  - alu_enable=1; ALU inputs come from the latched registers.
  - At the edge: rsp_data <= alu_data_out, rsp_id <= latched id, rsp_valid <= 1, state <= RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On rsp_ready with no req_valid: rsp_valid <= 0, state <= IDLE.
  - On rsp_ready with any req_valid: the grant and the response retire in the same edge, and state <= EXEC.
- Latency:
  - Request handshake at edge N gives rsp_valid=1 after edge N+1.
  - Peak throughput is one operation per 2 cycles, reached when rsp_ready is held high.
- alu_enable=0 in IDLE and RESP. ALU inputs hold their last latched values; they are never driven from unregistered request inputs.
- A requester that drops req_valid before its grant loses nothing; no request state is stored.
- Simultaneous requests: exactly one grant per cycle; the losers wait with req_ready=0.
- rsp_ready is ignored while rsp_valid=0.
- Width rules: no arithmetic besides the mod-NUM_REQ pointer increment, which wraps NUM_REQ-1 to 0.

Decomposition:
- Shared package alu_pkg holds:
  - SEL_SIZE, SHIFT_SIZE and XLEN defaults
  - ALU select encodings (enum alu_op_e) shared with arithmeticLogicUnit
  - typedef alu_req_t {sel, shift_amt, data_a, data_b}
  - state enum arb_state_e {IDLE, EXEC, RESP}
- One sub-module, rr_arbiter (req vector plus pointer in, one-hot grant out, purely combinational), reusable elsewhere.

Test Plan:
- Single request: req_valid=01, sel=ADD, a=5, b=7, rsp_ready=1 -> req_ready=01 at cycle 0; alu_enable=1 at cycle 1; rsp_valid=1, rsp_id=0, rsp_data=12 at cycle 2.
- Simultaneous requests after reset: both valid, SUB 10-3 and XOR F0^0F -> requester 0 served first (rsp_data=7, id 0), then requester 1 (rsp_data=FF, id 1); rr_ptr=0 at the end.
- Fairness: both valid continuously for 8 operations -> rsp_id sequence 0,1,0,1,0,1,0,1 with one response every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_id and rsp_data stable; req_ready=0 and alu_enable=0 throughout; completes on rsp_ready=1.
- Shift op: sel=SLL, shift_amt=31, a=1 -> rsp_data=0x80000000.
- Reset mid-op: rst_n=0 during EXEC -> next cycle state=IDLE, rsp_valid=0, all outputs 0, and no response is issued for the dropped operation.
